// File: rtl/fifo_nd_regout_pkg.sv
// Shared constants helpers for the registered-output FIFO.
package fifo_nd_regout_pkg;

    function automatic int clog2(input int value);
        int bits;
        int v;
        bits = 0;
        v = value - 1;
        while (v > 0) begin
            bits = bits + 1;
            v = v >> 1;
        end
        return bits;
    endfunction

    // A single-entry ring still needs a one-bit pointer to be a legal vector.
    function automatic int ptr_bits(input int entries);
        return (entries > 1) ? clog2(entries) : 1;
    endfunction

endpackage

// File: rtl/fifo_nd_regout_ring_mem.sv
// DEPTH-1 x WIDTH storage for the FIFO ring: one write port, one asynchronous read port.
module ring_mem_1r1w #(
    parameter int WIDTH   = 64,
    parameter int ENTRIES = 3,
    parameter int AW      = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_nd_regout.sv
// N-entry valid/ready FIFO whose read side comes straight from an output register.
// Optional synchronous flush port enabled by defining FIFO_ND_REGOUT_FLUSH_EN.
module fifo_nd_regout
    import fifo_nd_regout_pkg::*;
#(
    parameter int   WIDTH = 64,
    parameter int   DEPTH = 4,
    localparam int  CBITS = clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
`ifdef FIFO_ND_REGOUT_FLUSH_EN
    input  logic             flush,
`endif
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CBITS-1:0] count
);

    localparam int RING = DEPTH - 1;
    localparam int PW   = ptr_bits(RING);
    localparam logic [PW-1:0]    PTR_LAST = PW'(RING - 1);
    localparam logic [CBITS-1:0] FULL     = CBITS'(DEPTH);

    logic [CBITS-1:0] count_q;
    logic [CBITS-1:0] ring_cnt;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [WIDTH-1:0] ob_data;
    logic             ob_valid;
    logic [WIDTH-1:0] ring_rdata;
    logic             wr_fire;
    logic             rd_fire;
    logic             ld;
    logic             ring_empty;
    logic             ring_wr;
    logic             ring_rd;
    logic             ring_we;
    logic             clear;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

`ifdef FIFO_ND_REGOUT_FLUSH_EN
    assign clear = rst || flush;
`else
    assign clear = rst;
`endif

    assign a_ready    = (count_q != FULL);
    assign wr_fire    = a_valid && a_ready;
    assign rd_fire    = ob_valid && b_ready;
    assign ld         = !ob_valid || rd_fire;
    assign ring_empty = (ring_cnt == '0);
    // A write bypasses the ring only when the output register is loading from an empty ring.
    assign ring_wr    = wr_fire && !(ld && ring_empty);
    assign ring_rd    = ld && !ring_empty;
    assign ring_we    = ring_wr && !clear;

    ring_mem_1r1w #(
        .WIDTH   (WIDTH),
        .ENTRIES (RING),
        .AW      (PW)
    ) u_ring (
        .clk   (clk),
        .we    (ring_we),
        .waddr (wr_ptr),
        .wdata (a_data),
        .raddr (rd_ptr),
        .rdata (ring_rdata)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q  <= '0;
            ring_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            ob_data  <= '0;
            ob_valid <= 1'b0;
        end else begin
            if (ld) begin
                if (!ring_empty) begin
                    ob_data  <= ring_rdata;
                    ob_valid <= 1'b1;
                    rd_ptr   <= ptr_next(rd_ptr);
                end else if (wr_fire) begin
                    ob_data  <= a_data;
                    ob_valid <= 1'b1;
                end else begin
                    ob_valid <= 1'b0;
                end
            end
            if (ring_wr) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            case ({ring_wr, ring_rd})
                2'b10:   ring_cnt <= ring_cnt + 1'b1;
                2'b01:   ring_cnt <= ring_cnt - 1'b1;
                default: ring_cnt <= ring_cnt;
            endcase
            case ({wr_fire, rd_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign b_data  = ob_data;
    assign b_valid = ob_valid;
    assign count   = count_q;

endmodule

// File: tb/tb_fifo_nd_regout.sv
// Self-checking bench for fifo_nd_regout: directed vector table plus a queue scoreboard.
module tb_fifo_nd_regout;

    localparam int WIDTH = 64;
    localparam int DEPTH = 4;
    localparam int CBITS = 4;

    logic             clk;
    logic             rst;
`ifdef FIFO_ND_REGOUT_FLUSH_EN
    logic             flush;
`endif
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [CBITS-1:0] count;

    int errors = 0;
    int checks = 0;
    logic [WIDTH-1:0] model_q[$];

    typedef struct {
        logic             av;
        logic [WIDTH-1:0] ad;
        logic             br;
        logic             ev;
        logic [WIDTH-1:0] ed;
        logic [CBITS-1:0] ec;
        logic             er;
    } vec_t;

    vec_t vecs[$];

    fifo_nd_regout #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
`ifdef FIFO_ND_REGOUT_FLUSH_EN
        .flush   (flush),
`endif
        .a_data  (a_data),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .b_data  (b_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic av, input logic [WIDTH-1:0] ad, input logic br,
                                input logic ev, input logic [WIDTH-1:0] ed,
                                input logic [CBITS-1:0] ec, input logic er);
        vec_t v;
        v.av = av; v.ad = ad; v.br = br;
        v.ev = ev; v.ed = ed; v.ec = ec; v.er = er;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive inputs just after the falling edge; outputs are sampled 1 time unit later.
    task automatic applyStimulus(input logic av, input logic [WIDTH-1:0] ad, input logic br);
        @(negedge clk);
        a_valid = av;
        a_data  = ad;
        b_ready = br;
        #1;
    endtask

    task automatic modelStep(input string tag, input logic av, input logic [WIDTH-1:0] ad,
                             input logic br);
        int  sz;
        logic w;
        logic r;
        applyStimulus(av, ad, br);
        sz = model_q.size();
        checkOutput({tag, " count"},   WIDTH'(count),   WIDTH'(sz));
        checkOutput({tag, " a_ready"}, WIDTH'(a_ready), WIDTH'(sz != DEPTH));
        checkOutput({tag, " b_valid"}, WIDTH'(b_valid), WIDTH'(sz != 0));
        if (sz != 0) begin
            checkOutput({tag, " b_data"}, b_data, model_q[0]);
        end
        w = av && (sz != DEPTH);
        r = br && (sz != 0);
        if (r) begin
            void'(model_q.pop_front());
        end
        if (w) begin
            model_q.push_back(ad);
        end
    endtask

    initial begin
        rst     = 1'b1;
`ifdef FIFO_ND_REGOUT_FLUSH_EN
        flush   = 1'b0;
`endif
        a_valid = 1'b1;
        a_data  = 64'hDEAD;
        b_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        a_valid = 1'b0;
        #1;
        checkOutput("reset count",   WIDTH'(count),   64'd0);
        checkOutput("reset b_valid", WIDTH'(b_valid), 64'd0);
        checkOutput("reset b_data",  b_data,          64'd0);
        checkOutput("reset a_ready", WIDTH'(a_ready), 64'd1);

        // Expected columns describe the state seen in the same cycle the inputs are applied.
        vecs.push_back(mk(1, 64'hA5, 0, 0, 64'h0,  4'd0, 1));
        vecs.push_back(mk(0, 64'h0,  0, 1, 64'hA5, 4'd1, 1));
        vecs.push_back(mk(0, 64'h0,  0, 1, 64'hA5, 4'd1, 1));
        vecs.push_back(mk(0, 64'h0,  1, 1, 64'hA5, 4'd1, 1));
        vecs.push_back(mk(1, 64'h1,  0, 0, 64'h0,  4'd0, 1));
        vecs.push_back(mk(1, 64'h2,  0, 1, 64'h1,  4'd1, 1));
        vecs.push_back(mk(1, 64'h3,  0, 1, 64'h1,  4'd2, 1));
        vecs.push_back(mk(1, 64'h4,  0, 1, 64'h1,  4'd3, 1));
        vecs.push_back(mk(1, 64'h5,  0, 1, 64'h1,  4'd4, 0));
        vecs.push_back(mk(1, 64'h5,  1, 1, 64'h1,  4'd4, 0));
        vecs.push_back(mk(0, 64'h0,  1, 1, 64'h2,  4'd3, 1));
        vecs.push_back(mk(0, 64'h0,  1, 1, 64'h3,  4'd2, 1));
        vecs.push_back(mk(0, 64'h0,  1, 1, 64'h4,  4'd1, 1));
        vecs.push_back(mk(0, 64'h0,  0, 0, 64'h0,  4'd0, 1));
        vecs.push_back(mk(1, 64'h10, 0, 0, 64'h0,  4'd0, 1));
        vecs.push_back(mk(1, 64'h11, 1, 1, 64'h10, 4'd1, 1));
        vecs.push_back(mk(0, 64'h0,  0, 1, 64'h11, 4'd1, 1));
        vecs.push_back(mk(0, 64'h0,  1, 1, 64'h11, 4'd1, 1));
        vecs.push_back(mk(0, 64'h0,  0, 0, 64'h0,  4'd0, 1));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].av, vecs[i].ad, vecs[i].br);
            checkOutput($sformatf("vec%0d count", i),   WIDTH'(count),   WIDTH'(vecs[i].ec));
            checkOutput($sformatf("vec%0d a_ready", i), WIDTH'(a_ready), WIDTH'(vecs[i].er));
            checkOutput($sformatf("vec%0d b_valid", i), WIDTH'(b_valid), WIDTH'(vecs[i].ev));
            if (vecs[i].ev) begin
                checkOutput($sformatf("vec%0d b_data", i), b_data, vecs[i].ed);
            end
        end
        model_q.delete();

        // Reset while holding three entries.
        modelStep("prerst", 1, 64'h31, 0);
        modelStep("prerst", 1, 64'h32, 0);
        modelStep("prerst", 1, 64'h33, 0);
        modelStep("prerst", 0, 64'h0,  0);
        @(negedge clk);
        rst     = 1'b1;
        a_valid = 1'b1;
        a_data  = 64'h34;
        b_ready = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        a_valid = 1'b0;
        b_ready = 1'b0;
        #1;
        checkOutput("midrst count",   WIDTH'(count),   64'd0);
        checkOutput("midrst b_valid", WIDTH'(b_valid), 64'd0);
        checkOutput("midrst b_data",  b_data,          64'd0);
        checkOutput("midrst a_ready", WIDTH'(a_ready), 64'd1);
        model_q.delete();

        for (int i = 0; i < 100; i++) begin
            modelStep("stream", 1, WIDTH'(i), 1);
        end
        for (int i = 0; i < 8 && model_q.size() != 0; i++) begin
            modelStep("stream drain", 0, 64'h0, 1);
        end

        for (int i = 0; i < 10000; i++) begin
            modelStep("random", 1'($urandom_range(0, 1)), {$urandom, $urandom},
                      1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 8 && model_q.size() != 0; i++) begin
            modelStep("random drain", 0, 64'h0, 1);
        end
        modelStep("final empty", 0, 64'h0, 0);

`ifdef FIFO_ND_REGOUT_FLUSH_EN
        modelStep("preflush", 1, 64'h61, 0);
        modelStep("preflush", 1, 64'h62, 0);
        modelStep("preflush", 1, 64'h63, 0);
        @(negedge clk);
        flush   = 1'b1;
        a_valid = 1'b1;
        a_data  = 64'h77;
        b_ready = 1'b0;
        #1;
        checkOutput("flush a_ready", WIDTH'(a_ready), 64'd1);
        @(negedge clk);
        flush   = 1'b0;
        a_valid = 1'b0;
        #1;
        checkOutput("flush count",   WIDTH'(count),   64'd0);
        checkOutput("flush b_valid", WIDTH'(b_valid), 64'd0);
        checkOutput("flush b_data",  b_data,          64'd0);
        model_q.delete();
        for (int i = 0; i < 4; i++) begin
            modelStep("postflush", 0, 64'h0, 1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_nd_regout.md
Name: fifo_nd_regout

Overview:
- N-entry valid/ready FIFO with fully registered read side, the complement of the 1-deep fall-through buffer.
- No combinational path a_* -> b_* and no combinational path b_ready -> a_ready, so it can cut timing between pipeline stages, e.g. the fetch -> decode and LSU response paths.
- Full throughput: one transfer per cycle in steady state. Minimum latency is 1 cycle.

Parameters:
- WIDTH, 64, payload width in bits.
- DEPTH, 4, total capacity in entries (output register included); power of two, >= 2.
- CBITS, $clog2(DEPTH)+1, width of the count output; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high. Clock clk.
- a_data  in  WIDTH  write-side payload.
- a_valid  in  1  write-side valid.
- a_ready  out  1  write-side ready; a function of registers only.
- b_data  out  WIDTH  read-side payload, driven directly from the output register.
- b_valid  out  1  read-side valid, registered.
- b_ready  in  1  read-side ready.
- count  out  CBITS  occupancy, output register plus ring entries.

Behaviour:
- Storage:
  - Output register (ob_data, ob_valid) plus a ring of DEPTH-1 entries.
  - Ring uses rd_ptr/wr_ptr of $clog2(DEPTH-1) bits, wrapping at DEPTH-2 -> 0, and a ring occupancy counter.
- Handshake:
  - A write fires when a_valid && a_ready.
  - A read fires when b_valid && b_ready.
  - a_valid and b_ready may toggle freely; data is never duplicated or dropped.
- a_ready = (count != DEPTH).
  - a_ready does not rise in the same cycle as a read at full; the first write after that read is accepted the following cycle.
- Output register load condition, ld = !ob_valid || read fire:
  - Ring non-empty: ob <= ring[rd_ptr], rd_ptr advances. A concurrent write goes into the ring at wr_ptr.
  - Ring empty and write fires: ob <= a_data directly (bypass into the register, never combinational to b_*).
  - Ring empty, no write: ob_valid <= 0.
- No ld and write fires: the write goes to ring[wr_ptr], wr_ptr advances.
- Latency: a write accepted at cycle N into an empty FIFO gives b_valid=1 with that data at N+1.
- count update:
  - +1 on write only, -1 on read only.
  - Unchanged on simultaneous write and read, or on neither.
- Ordering: strict FIFO order, including across bypass/ring transitions.
- Empty: b_valid=0, count=0, and b_ready is ignored.
- Full (count=DEPTH): a_ready=0 and a_valid is ignored. A read still fires normally and count drops to DEPTH-1.
- Reset:
  - count=0, b_valid=0, a_ready=1 from the first cycle after reset.
  - b_data=0; the output register is cleared. Ring contents are not reset.
  - Pointers are 0.
  - Reset mid-operation discards all contents in one cycle. Inputs are ignored while rst=1.
- b_data is stable while b_valid && !b_ready.

Optional Feature:
- Macro FIFO_ND_REGOUT_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit).
  - flush=1 at a clock edge gives the same effect as reset on count, b_valid, b_data and the pointers.
  - Priority: rst > flush > write/read. A write or read presented in the flush cycle is discarded and not counted.
  - a_ready stays 1 during flush unless the FIFO was full.
- Undefined: no flush port, and no flush logic is synthesised.

Decomposition:
- Shared package: no new typedefs.
- The CBITS/pointer-width calculation uses the common clog2 helper already in the shared constants include.
- One natural sub-module: ring_mem_1r1w, a DEPTH-1 x WIDTH register array with 1 write port and 1 asynchronous read port. This keeps pointer/count control separate from storage so the storage can be swapped for an inferred RAM later.

Test Plan:
- Single beat: DEPTH=4; write 0xA5 at cycle 0 with b_ready=0 -> b_valid=1, b_data=0xA5 at cycle 1, count=1; b_data held until b_ready=1; count=0 after the read.
- Fill/drain: write 0x1..0x4 back-to-back with b_ready=0 -> a_ready=0 after the 4th write, count=4. A 5th write 0x5 is not accepted. Then b_ready=1 -> reads 0x1,0x2,0x3,0x4 in order; a_ready=1 the cycle after the first read.
- Streaming: a_valid=1 and b_ready=1 continuously with incrementing data 0..99 -> 100 reads, in order, one per cycle after 1-cycle latency; count stays 1.
- Wrap and random: random a_valid/b_ready at 50% for 10k cycles -> scoreboard match, count equals the model at every cycle, ring pointers wrap at least 100 times.
- Boundaries:
  - Simultaneous write and read at count=4 -> write rejected, count=3.
  - Simultaneous write and read at count=1 -> new data goes to the output register the next cycle, count stays 1.
  - rst asserted with count=3 -> count=0, b_valid=0, b_data=0 the next cycle.
- Flush (FIFO_ND_REGOUT_FLUSH_EN): flush with count=3 and a concurrent write 0x77 -> count=0, b_valid=0; 0x77 is never read out.
